// File: rtl/audio_frame_assembler.sv
// audio_frame_assembler: packs serial audio samples into fft windows (define AUDIO_FRAME_OVERLAP_EN for 50% overlapped windows)
module audio_frame_assembler #(
  parameter int N        = 1024,
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 32,
  parameter int OVF_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic signed [SAMPLE_W-1:0] s_data,
  input  logic                       hold,
  output logic [N*SLOT_W-1:0]        window,
  output logic                       window_valid,
  output logic [15:0]                frame_cnt,
  output logic [OVF_W-1:0]           overrun_cnt
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, FILL, PUBLISH} state_t;

  state_t              r_state;
  logic                r_ready;
  logic                r_window_valid;
  logic [N*SLOT_W-1:0] r_shadow;
  logic [N*SLOT_W-1:0] r_window;
  logic [CW-1:0]       r_cnt;
  logic [15:0]         r_frame_cnt;
  logic [OVF_W-1:0]    r_ovf;
  logic                w_xfer;
  logic [CW-1:0]       w_last;
  logic [SLOT_W-1:0]   w_slot;

  assign w_xfer = s_valid & r_ready;
  assign w_slot = {s_data, {(SLOT_W-SAMPLE_W){1'b0}}};

`ifdef AUDIO_FRAME_OVERLAP_EN
  logic r_primed;
  assign w_last = r_primed ? CW'(N/2-1) : CW'(N-1);
  // the first publish attempt ends priming; later frames advance by half a window
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_primed <= 1'b0;
    else if (r_state == PUBLISH) r_primed <= 1'b1;
`else
  assign w_last = CW'(N-1);
`endif

  // newest sample enters the top slot, so once full, slot 0 holds the oldest of the last N samples
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_shadow <= '0;
    else if (w_xfer) r_shadow <= {w_slot, r_shadow[N*SLOT_W-1:SLOT_W]};

  // frame sequencing: count transfers, publish or drop the completed frame, keep stats
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state        <= IDLE;
      r_ready        <= 1'b0;
      r_window_valid <= 1'b0;
      r_window       <= '0;
      r_cnt          <= '0;
      r_frame_cnt    <= '0;
      r_ovf          <= '0;
    end else begin
      r_window_valid <= 1'b0;
      if (w_xfer) r_cnt <= (r_state == FILL && r_cnt == w_last) ? '0 : r_cnt + 1'b1;
      case (r_state)
        IDLE: begin
          r_state <= FILL;
          r_ready <= 1'b1;
        end
        FILL: if (w_xfer && r_cnt == w_last) r_state <= PUBLISH;
        PUBLISH: begin
          r_state <= FILL;
          if (!hold) begin
            r_window       <= r_shadow;
            r_window_valid <= 1'b1;
            r_frame_cnt    <= r_frame_cnt + 1'b1;
          end else if (~&r_ovf) r_ovf <= r_ovf + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end

  assign s_ready      = r_ready;
  assign window       = r_window;
  assign window_valid = r_window_valid;
  assign frame_cnt    = r_frame_cnt;
  assign overrun_cnt  = r_ovf;
endmodule

// File: tb/tb_audio_frame_assembler.sv
// tb_audio_frame_assembler: sample-history model plus directed frames for audio_frame_assembler
module tb_audio_frame_assembler;
  localparam int N  = 1024;
  localparam int SW = 32;
  localparam int OW = 8;
`ifdef AUDIO_FRAME_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif
  localparam int STEP = OVL ? N/2 : N;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                s_valid = 1'b0;
  logic                hold = 1'b0;
  logic signed [15:0]  s_data = '0;
  logic                s_ready;
  logic                window_valid;
  logic [N*SW-1:0]     window;
  logic [15:0]         frame_cnt;
  logic [OW-1:0]       overrun_cnt;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  audio_frame_assembler dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .hold(hold), .window(window), .window_valid(window_valid),
    .frame_cnt(frame_cnt), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] slot(input int k);
    return window[k*SW +: SW];
  endfunction

  // model: history of accepted samples; a frame completes every N (then STEP) samples
  // and is published or dropped on the following edge depending on hold
  bit          m_ready = 0, m_pend = 0, m_wv = 0, m_primed = 0;
  int          m_cnt = 0;
  int          m_ovf = 0;
  logic [15:0] m_fcnt = '0;
  logic [15:0] m_hist[$];
  logic [15:0] m_snap[N];
  logic [15:0] m_win[N];

  initial for (int k = 0; k < N; k++) m_win[k] = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready = 0; m_pend = 0; m_wv = 0; m_primed = 0; m_cnt = 0; m_ovf = 0; m_fcnt = '0;
      m_hist.delete();
      for (int k = 0; k < N; k++) m_win[k] = '0;
    end else begin
      m_wv = 0;
      if (m_pend) begin
        if (!hold) begin
          m_win = m_snap;
          m_wv = 1;
          m_fcnt++;
        end else if (m_ovf < 255) m_ovf++;
        m_pend = 0;
        m_primed = 1;
      end
      if (s_valid && m_ready) begin
        m_hist.push_back(s_data);
        if (m_hist.size() > N) void'(m_hist.pop_front());
        m_cnt++;
        if (m_cnt == ((OVL && m_primed) ? N/2 : N)) begin
          m_cnt = 0;
          m_pend = 1;
          for (int k = 0; k < N; k++) m_snap[k] = m_hist[k];
        end
      end
      m_ready = 1;
    end
  end

  logic [31:0] strobe_slot0[16];
  int          strobe_cyc[16];
  int          n_strobes = 0;

  always @(negedge clk) begin
    int bad;
    #1;
    chk("s_ready", 32'(s_ready), 32'(m_ready));
    chk("window_valid", 32'(window_valid), 32'(m_wv));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
    chk("overrun_cnt", 32'(overrun_cnt), 32'(m_ovf));
    bad = -1;
    for (int k = 0; k < N; k++)
      if (window[k*SW +: SW] !== {m_win[k], 16'h0000}) begin
        bad = k;
        break;
      end
    n_checks++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL window slot %0d: got %h expected %h", bad, window[bad*SW +: SW], {m_win[bad], 16'h0000});
    end
    if (window_valid === 1'b1 && n_strobes < 16) begin
      strobe_slot0[n_strobes] = window[31:0];
      strobe_cyc[n_strobes] = cyc;
      n_strobes++;
    end
  end

  task automatic stream(input logic [15:0] base, input int n, input bit inc, input bit gaps, output int last);
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0 && i % 100 == 0) begin
        @(negedge clk);
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
      end
      @(negedge clk);
      s_valid = 1'b1;
      s_data = inc ? 16'(base + 16'(i)) : base;
    end
    @(negedge clk);
    s_valid = 1'b0;
    last = cyc;
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst_slot0", slot(0), 32'h0);
    chk("rst_ready", 32'(s_ready), 32'h0);
    chk("rst_fcnt", 32'(frame_cnt), 32'h0);
    chk("rst_ovf", 32'(overrun_cnt), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    stream(16'd0, N, 1, 0, t);
    repeat (3) @(negedge clk);
    chk("f1_latency", 32'(strobe_cyc[0]), 32'(t + 1));
    chk("f1_strobes", 32'(n_strobes), 32'd1);
    chk("f1_slot0", slot(0), 32'h0000_0000);
    chk("f1_slot1023", slot(N-1), 32'h03FF_0000);
    chk("f1_fcnt", 32'(frame_cnt), 32'd1);

    stream(16'd1024, N, 1, 1, t);
    repeat (3) @(negedge clk);
    chk("f2_strobes", 32'(n_strobes), OVL ? 32'd3 : 32'd2);
    chk("f2_win2_slot0", strobe_slot0[1], OVL ? 32'h0200_0000 : 32'h0400_0000);
    chk("f2_slot0", slot(0), 32'h0400_0000);
    chk("f2_fcnt", 32'(frame_cnt), OVL ? 32'd3 : 32'd2);

    hold = 1'b1;
    stream(16'h7000, STEP, 1, 0, t);
    repeat (3) @(negedge clk);
    hold = 1'b0;
    chk("hold_slot0", slot(0), 32'h0400_0000);
    chk("hold_fcnt", 32'(frame_cnt), OVL ? 32'd3 : 32'd2);
    chk("hold_ovf", 32'(overrun_cnt), 32'd1);

    stream(16'd2048, STEP, 1, 0, t);
    repeat (3) @(negedge clk);
    chk("f3_slot0", slot(0), OVL ? 32'h7000_0000 : 32'h0800_0000);
    chk("f3_slot1023", slot(N-1), OVL ? 32'h09FF_0000 : 32'h0BFF_0000);
    chk("f3_fcnt", 32'(frame_cnt), OVL ? 32'd4 : 32'd3);

    stream(16'h1000, 500, 1, 0, t);
    rst_n = 1'b0;
    #1;
    chk("rst2_ready", 32'(s_ready), 32'h0);
    chk("rst2_valid", 32'(window_valid), 32'h0);
    chk("rst2_window_any", 32'(|window), 32'h0);
    chk("rst2_fcnt", 32'(frame_cnt), 32'h0);
    chk("rst2_ovf", 32'(overrun_cnt), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    stream(16'd100, N, 1, 0, t);
    repeat (3) @(negedge clk);
    chk("post_rst_slot0", slot(0), 32'h0064_0000);
    chk("post_rst_slot1023", slot(N-1), 32'h0463_0000);
    chk("post_rst_fcnt", 32'(frame_cnt), 32'd1);

    stream(16'h8000, N, 0, 0, t);
    repeat (3) @(negedge clk);
    chk("neg_slot0", slot(0), 32'h8000_0000);
    chk("neg_slot511", slot(511), 32'h8000_0000);
    chk("neg_slot1023", slot(N-1), 32'h8000_0000);
    chk("neg_fcnt", 32'(frame_cnt), OVL ? 32'd3 : 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/audio_frame_assembler.md
Name: audio_frame_assembler

Overview:
- Upstream feeder for the combinational `fft` block.
- Accepts a serial stream of signed 16-bit audio samples and packs N of them into the 32768-bit `window` bus that `fft` consumes.
- Publishes a complete window with a one-cycle strobe and holds it stable until the next frame is published.
- Counts frames lost while the consumer asserts hold.

Parameters:
- N, 1024: samples per window. N*SLOT_W must equal 32768.
- SAMPLE_W, 16: input sample width, signed two's complement.
- SLOT_W, 32: bits per window slot, packed as {re[15:0], im[15:0]}.
- OVF_W, 8: width of the overrun counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block can accept a sample this cycle.
- s_data  in  SAMPLE_W  signed audio sample.
- hold  in  1  consumer busy; while high, `window` must not change.
- window  out  N*SLOT_W  published frame, drives `fft.window`.
- window_valid  out  1  one-cycle strobe on the cycle `window` changes.
- frame_cnt  out  16  frames published, wraps at 65535->0.
- overrun_cnt  out  OVF_W  frames dropped due to hold, saturates at all-ones.

Behaviour:
- Reset (async assert, sync release): window=0, window_valid=0, frame_cnt=0, overrun_cnt=0, s_ready=0, fill counter=0, state=IDLE.
- FSM states: IDLE, FILL, PUBLISH.
- IDLE -> FILL one cycle after reset release; s_ready=1 from that cycle on.
- Transfer: occurs when s_valid & s_ready.
  - Sample accepted on transfer k goes into shadow slot k (k = 0..N-1).
  - Slot k is bits [SLOT_W*k+31 : SLOT_W*k]: re = s_data, im = 16'h0000.
  - Slot 0 holds the oldest sample.
- FILL:
  - Fill counter increments per transfer.
  - On the transfer that fills slot N-1, go to PUBLISH next cycle and reset the fill counter to 0.
- PUBLISH lasts exactly one cycle:
  - If hold=0: copy shadow -> window, pulse window_valid=1 for that cycle, frame_cnt+1.
  - If hold=1: window unchanged, window_valid=0, overrun_cnt+1 (saturating), frame discarded.
  - Either way, return to FILL.
- s_ready is 1 in PUBLISH as well. A sample arriving in the PUBLISH cycle goes to slot 0 of the next frame, so there is no stall and no sample is lost.
- Latency: the last sample's transfer at edge T makes window/window_valid visible after edge T+1.
- s_valid=0 gaps pause filling; partial frames are retained indefinitely.
- hold only matters in PUBLISH. Raising hold mid-FILL has no effect until publish.
- Reset mid-fill discards the partial frame and clears `window` to 0.
- frame_cnt wraps; overrun_cnt does not.

Optional Feature:
- Macro: AUDIO_FRAME_OVERLAP_EN.
- Defined (50% overlap):
  - After the first full frame, publish every N/2 accepted samples.
  - The shadow acts as a shift buffer. Each publish window contains the newest N samples, oldest in slot 0; the oldest N/2 samples are discarded.
  - Fill counter runs 0..N/2-1 after the first frame.
  - Reset returns to full-N priming.
- Undefined: non-overlapping frames every N samples, as described in Behaviour.

Test Plan:
- Reset, then stream samples 0,1,...,1023 with s_valid=1 and hold=0 -> window_valid pulses once, exactly 1 cycle after the 1024th transfer. Slot k equals {k[15:0], 16'h0}, so window[31:0]=0 and window[32767:32736]=32'h03FF_0000. frame_cnt=1.
- Stream 2048 samples with a 3-cycle s_valid=0 gap every 100 samples -> two strobes, no lost samples. Second window slot 0 = sample 1024. frame_cnt=2.
- Hold=1 across the second publish cycle -> window still equals frame 1, no strobe, overrun_cnt=1. Third frame with hold=0 publishes samples 2048..3071.
- Assert rst_n=0 after 500 samples, then release and stream 1024 samples -> all outputs 0 during reset. First strobe arrives after 1024 new samples; window holds only post-reset data.
- Negative samples: stream 16'h8000 into every slot -> every slot = 32'h8000_0000, no sign extension into the im field.
- With AUDIO_FRAME_OVERLAP_EN defined, stream 2048 samples -> strobes after samples 1024, 1536 and 2048. The second window's slot 0 = sample 512; the third window's slot 0 = sample 1024.
